// File: rtl/glitch_pkg.sv
// Shared types and default sizes for the trigger qualifier.
//   state_e    : qualifier FSM states
//   edge_sel_e : encoding of the edge_sel input
// Build macro TRIG_FILTER_EN (see sync_edge_det) enables the stability filter.
package glitch_pkg;

  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_COUNT_W     = 16;
  localparam int unsigned DEF_FILTER_LEN  = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_FIRE    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    EDGE_RISE  = 2'b00,
    EDGE_FALL  = 2'b01,
    EDGE_BOTH  = 2'b10,
    EDGE_LEVEL = 2'b11
  } edge_sel_e;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizes the asynchronous target signal, optionally filters it, and
// decodes a one-cycle qualifying event against a history flop.
// Build macro: TRIG_FILTER_EN -- when defined, the synchronized level is only
// accepted after FILTER_LEN consecutive equal samples.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   target_sig  : raw asynchronous input
//   edge_sel    : 00 rising, 01 falling, 10 both, 11 high level
//   evt_c       : combinational event flag for the current cycle
module sync_edge_det
  import glitch_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,  // legal 2..4
  parameter int unsigned FILTER_LEN  = DEF_FILTER_LEN    // legal >= 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       target_sig,
  input  logic [1:0] edge_sel,
  output logic       evt_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   qual;
  logic                   hist_q;

  // Metastability chain; the last stage is the first usable sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], target_sig};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef TRIG_FILTER_EN
  localparam int unsigned FCNT_W = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

  logic [FCNT_W-1:0] fcnt_q;
  logic              filt_q;

  // Count consecutive samples that disagree with the accepted level; the
  // FILTER_LEN-th disagreeing sample flips the accepted level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_q <= '0;
      filt_q <= 1'b0;
    end else if (sync_out == filt_q) begin
      fcnt_q <= '0;
    end else if (fcnt_q == FCNT_W'(FILTER_LEN - 1)) begin
      fcnt_q <= '0;
      filt_q <= sync_out;
    end else begin
      fcnt_q <= fcnt_q + FCNT_W'(1);
    end
  end

  assign qual = filt_q;
`else
  // FILTER_LEN has no effect when the filter is not built.
  if (FILTER_LEN == 0) begin : g_filter_len_unused
  end

  assign qual = sync_out;
`endif

  // History of the qualified level for edge comparison.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= 1'b0;
    end else begin
      hist_q <= qual;
    end
  end

  // Event decode per selected edge mode.
  always_comb begin
    evt_c = 1'b0;
    unique case (edge_sel_e'(edge_sel))
      EDGE_RISE:  evt_c = qual & ~hist_q;
      EDGE_FALL:  evt_c = ~qual & hist_q;
      EDGE_BOTH:  evt_c = qual ^ hist_q;
      EDGE_LEVEL: evt_c = qual;
    endcase
  end

endmodule

// File: rtl/trigger_qualifier.sv
// Trigger qualifier: counts qualifying events on an asynchronous target
// signal after being armed and raises a level trigger to the glitch stage
// once the requested number of events has been seen.
// Build macro: TRIG_FILTER_EN -- adds a FILTER_LEN-sample stability filter
// in front of the edge detector (see sync_edge_det).
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   arm, disarm  : one-cycle arm/re-arm and abort requests
//   target_sig   : asynchronous signal from the target
//   edge_sel     : 00 rising, 01 falling, 10 both, 11 high level
//   match_count  : events required to fire (0 behaves as 1)
//   glitch_done  : completion from the glitch stage
//   trigger      : registered trigger level
//   armed        : registered, high while armed
//   event_count  : registered count of events since last arm (saturating)
module trigger_qualifier
  import glitch_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned COUNT_W     = DEF_COUNT_W,
  parameter int unsigned FILTER_LEN  = DEF_FILTER_LEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic               disarm,
  input  logic               target_sig,
  input  logic [1:0]         edge_sel,
  input  logic [COUNT_W-1:0] match_count,
  input  logic               glitch_done,
  output logic               trigger,
  output logic               armed,
  output logic [COUNT_W-1:0] event_count
);

  localparam int unsigned CNT_EXT_W = COUNT_W + 1;

  state_e               state_q;
  logic                 evt_c;
  logic [COUNT_W-1:0]   thresh_c;
  logic [CNT_EXT_W-1:0] cnt_inc_c;
  logic [COUNT_W-1:0]   cnt_sat_c;
  logic                 hit_c;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_sync_edge_det (
    .clk        (clk),
    .rst        (rst),
    .target_sig (target_sig),
    .edge_sel   (edge_sel),
    .evt_c      (evt_c)
  );

  // Threshold, saturating increment and fire decision for this cycle's event.
  always_comb begin
    thresh_c  = (match_count == '0) ? COUNT_W'(1) : match_count;
    cnt_inc_c = {1'b0, event_count} + CNT_EXT_W'(1);
    cnt_sat_c = cnt_inc_c[COUNT_W] ? '1 : cnt_inc_c[COUNT_W-1:0];
    hit_c     = (cnt_inc_c >= {1'b0, thresh_c});
  end

  // Qualifier FSM with registered outputs; disarm overrides everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      trigger     <= 1'b0;
      armed       <= 1'b0;
      event_count <= '0;
    end else if (disarm) begin
      state_q <= ST_IDLE;
      trigger <= 1'b0;
      armed   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          trigger <= 1'b0;
          if (arm) begin
            state_q     <= ST_ARMED;
            armed       <= 1'b1;
            event_count <= '0;
          end
        end
        ST_ARMED: begin
          // Re-arm discards any event arriving in the same cycle.
          if (arm) begin
            event_count <= '0;
          end else if (evt_c) begin
            event_count <= cnt_sat_c;
            if (hit_c) begin
              state_q <= ST_FIRE;
              trigger <= 1'b1;
              armed   <= 1'b0;
            end
          end
        end
        ST_FIRE: begin
          if (glitch_done) begin
            state_q <= ST_RELEASE;
            trigger <= 1'b0;
          end
        end
        ST_RELEASE: begin
          trigger <= 1'b0;
          if (!glitch_done) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          trigger <= 1'b0;
          armed   <= 1'b0;
        end
      endcase
    end
  end

endmodule
